trap_filter_param: RTL and testbench
====================================

TRAP_FILTER_PARAM -- requirements
Module: trap_filter_param

Interface
REQ-001 SIZE_ADC_DATA, 12, unsigned ADC sample width.
REQ-002 SIZE_FILTER_DATA, 28, signed width of the accumulators and filter output.
REQ-003 K_DELAY, 13, long delay in samples; K_DELAY > L_DELAY >= 1.
REQ-004 L_DELAY, 7, short delay (rise length) in samples.
REQ-005 M_COEF, 16, pole-zero coefficient; non-negative integer, 0 allowed.
REQ-006 SIZE_TIME, 8, width of the peak-time counter.
REQ-007 clk  in  1  single clock; all logic on the rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 in_valid  in  1  input_data holds a new sample this cycle.
REQ-010 input_data  in  SIZE_ADC_DATA  unsigned ADC sample.
REQ-011 threshold  in  SIZE_FILTER_DATA  signed peak-detector arm level, sampled every cycle.
REQ-012 output_data  out  SIZE_FILTER_DATA  signed filter output s(n).
REQ-013 out_valid  out  1  output_data updated this cycle.
REQ-014 peak_value  out  SIZE_FILTER_DATA  maximum s(n) of the last completed pulse.
REQ-015 peak_time  out  SIZE_TIME  samples from arm to first occurrence of that maximum.
REQ-016 peak_valid  out  1  one-cycle strobe: peak_value/peak_time are newly valid.

Function
REQ-017 The sample index n advances only on cycles with in_valid=1; idle cycles change no filter state.
REQ-018 d(n) = v(n) - v(n-K_DELAY) - v(n-L_DELAY) + v(n-K_DELAY-L_DELAY), signed, SIZE_ADC_DATA+2 bits, exact.
REQ-019 p(n) = p(n-1) + d(n); r(n) = p(n) + M_COEF*d(n); s(n) = s(n-1) + r(n).
REQ-020 Evaluate p, r and s in SIZE_FILTER_DATA-bit two's complement; overflow wraps silently and is not saturated.
REQ-021 Pipeline: stage 1 delay lines and d; stage 2 p; stage 3 r; stage 4 s. Each stage carries a valid bit.
REQ-022 out_valid is asserted exactly 4 clocks after the in_valid that produced it, with output_data = s(n); this latency holds for back-to-back and gapped input.
REQ-023 Delay-line taps that predate the first sample after reset read 0.
REQ-024 Peak FSM states: IDLE, ARMED, DONE; it is evaluated only on out_valid cycles, except that DONE always returns to IDLE on the next clock.
REQ-025 IDLE -> ARMED when s > threshold (signed compare). On entry: max := s, time counter := 0, peak_time candidate := 0.
REQ-026 In ARMED, each valid sample increments the time counter. If s > max, then max := s and the candidate := counter; ties keep the earlier index.
REQ-027 ARMED -> DONE when s <= threshold. In that cycle, latch peak_value := max and peak_time := candidate, and raise peak_valid for one cycle.
REQ-028 The time counter saturates at all-ones and does not wrap.
REQ-029 A threshold change while ARMED takes effect at the next valid sample. No re-arm occurs in the DONE cycle.
REQ-030 peak_value and peak_time hold their values until the next DONE.

Reset
REQ-031 On reset low, immediately clear all delay lines, d, p, r, s and stage valid bits. Set output_data=0, out_valid=0, peak_value=0, peak_time=0, peak_valid=0, FSM=IDLE.
REQ-032 Reset mid-pulse discards the pulse; no peak_valid is issued for it.
REQ-033 After reset release, the first valid sample is n=0 with all history 0.

Structure
REQ-034 Shared package filter_pkg holds the peak FSM state enum and the default width constants SIZE_ADC_DATA and SIZE_FILTER_DATA.
REQ-035 One sub-module, delay_line (parameters WIDTH, DEPTH, enable-gated shift, async active-low clear), is used for the K_DELAY, L_DELAY and K_DELAY+L_DELAY taps.

Verification
REQ-036 M_COEF=0, threshold=250, impulse of 100 at n=0 then zeros -> s = 100,200,...,700 (n=0..6); 700 (n=7..12); 600,500,...,0 (n=13..19); 0 after. peak_valid at n=17 with peak_value=700, peak_time=4.
REQ-037 M_COEF=16, impulse of 10 at n=0 -> s(0)=170, s(6)=230, s(7..12)=70, s(13)=-100, s(19)=-160, s(n>=20)=0.
REQ-038 Same stimulus as REQ-036 with random 0-3 idle cycles between samples -> identical s sequence, and every out_valid lands 4 clocks after its in_valid.
REQ-039 Constant input 4095 from reset -> s settles to a constant after n >= K_DELAY+L_DELAY, and d = 0 thereafter.
REQ-040 reset asserted at n=9 of the REQ-036 pulse -> all outputs 0 immediately, no peak_valid, and the next impulse reproduces REQ-036 exactly.
REQ-041 threshold=800 with the REQ-036 stimulus -> FSM never leaves IDLE and peak_valid stays 0.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared definitions for the trapezoidal shaping filter: default widths and peak-detector states.
package filter_pkg;
    localparam int SIZE_ADC_DATA    = 12;
    localparam int SIZE_FILTER_DATA = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } peak_state_t;
endpackage

// File: rtl/delay_line.sv
// Enable-gated shift register; delayed is the sample shifted in DEPTH enables ago.
// Asynchronous active-low clear empties the whole line.
module delay_line #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] delayed
);
    logic [DEPTH-1:0][WIDTH-1:0] taps;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taps <= '0;
        end else if (en) begin
            taps[0] <= sample;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign delayed = taps[DEPTH-1];
endmodule

// File: rtl/trap_filter_param.sv
// Trapezoidal pulse-shaping filter (4-stage pipeline, fixed 4-clock latency) with a
// threshold-armed peak detector reporting the pulse maximum and its time from arming.
module trap_filter_param #(
    parameter int SIZE_ADC_DATA    = filter_pkg::SIZE_ADC_DATA,
    parameter int SIZE_FILTER_DATA = filter_pkg::SIZE_FILTER_DATA,
    parameter int K_DELAY          = 13,
    parameter int L_DELAY          = 7,
    parameter int M_COEF           = 16,
    parameter int SIZE_TIME        = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [SIZE_ADC_DATA-1:0]           input_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    output logic signed [SIZE_FILTER_DATA-1:0] output_data,
    output logic                               out_valid,
    output logic signed [SIZE_FILTER_DATA-1:0] peak_value,
    output logic [SIZE_TIME-1:0]               peak_time,
    output logic                               peak_valid
);
    import filter_pkg::*;

    localparam int AW = SIZE_ADC_DATA;
    localparam int DW = SIZE_ADC_DATA + 2;
    localparam int FW = SIZE_FILTER_DATA;
    localparam logic signed [FW-1:0] M_S = FW'(M_COEF);

    logic [AW-1:0]        tap_k, tap_l, tap_kl;
    logic signed [DW-1:0] d_next, d1;
    logic signed [FW-1:0] d_ext, p2, d2, r3;
    logic                 v1, v2, v3;

    delay_line #(.WIDTH(AW), .DEPTH(K_DELAY)) u_dl_k (
        .clk(clk), .reset(reset), .en(in_valid), .sample(input_data), .delayed(tap_k)
    );
    delay_line #(.WIDTH(AW), .DEPTH(L_DELAY)) u_dl_l (
        .clk(clk), .reset(reset), .en(in_valid), .sample(input_data), .delayed(tap_l)
    );
    delay_line #(.WIDTH(AW), .DEPTH(K_DELAY + L_DELAY)) u_dl_kl (
        .clk(clk), .reset(reset), .en(in_valid), .sample(input_data), .delayed(tap_kl)
    );

    // Two guard bits make the four-term difference exact for unsigned samples.
    assign d_next = $signed({2'b00, input_data}) - $signed({2'b00, tap_k})
                  - $signed({2'b00, tap_l})      + $signed({2'b00, tap_kl});
    assign d_ext  = {{(FW-DW){d1[DW-1]}}, d1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            out_valid   <= 1'b0;
            d1          <= '0;
            p2          <= '0;
            d2          <= '0;
            r3          <= '0;
            output_data <= '0;
        end else begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            if (in_valid) d1 <= d_next;
            if (v1) begin
                p2 <= p2 + d_ext;
                d2 <= d_ext;
            end
            if (v2) r3 <= p2 + M_S * d2;
            if (v3) output_data <= output_data + r3;
        end
    end

    peak_state_t           state, state_next;
    logic signed [FW-1:0]  pk_max, max_next, pv_next;
    logic [SIZE_TIME-1:0]  cnt, cnt_next, cnt_inc, cand, cand_next, pt_next;
    logic                  pkv_next;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        state_next = state;
        max_next   = pk_max;
        cnt_next   = cnt;
        cand_next  = cand;
        pv_next    = peak_value;
        pt_next    = peak_time;
        pkv_next   = 1'b0;
        case (state)
            IDLE: begin
                if (out_valid && (output_data > threshold)) begin
                    state_next = ARMED;
                    max_next   = output_data;
                    cnt_next   = '0;
                    cand_next  = '0;
                end
            end
            ARMED: begin
                if (out_valid) begin
                    if (output_data <= threshold) begin
                        state_next = DONE;
                        pv_next    = pk_max;
                        pt_next    = cand;
                        pkv_next   = 1'b1;
                    end else begin
                        cnt_next = cnt_inc;
                        // Strict compare keeps the first index of a flat top.
                        if (output_data > pk_max) begin
                            max_next  = output_data;
                            cand_next = cnt_inc;
                        end
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pk_max     <= '0;
            cnt        <= '0;
            cand       <= '0;
            peak_value <= '0;
            peak_time  <= '0;
            peak_valid <= 1'b0;
        end else begin
            state      <= state_next;
            pk_max     <= max_next;
            cnt        <= cnt_next;
            cand       <= cand_next;
            peak_value <= pv_next;
            peak_time  <= pt_next;
            peak_valid <= pkv_next;
        end
    end
endmodule

// File: tb/tb_trap_filter_param.sv
// Directed bench for trap_filter_param: impulse, gapped, coefficient, step, reset-abort and
// threshold cases, plus a narrow-counter instance for time-counter saturation.
module tb_trap_filter_param;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic [11:0]        input_data = '0;
    logic signed [27:0] threshold = 28'sd250;

    logic signed [27:0] s0, pv0, s16, pv16, ss, pvs;
    logic               ov0, pk0, ov16, pk16, ovs, pks;
    logic [7:0]         pt0, pt16;
    logic [1:0]         pts;

    always #5 clk = ~clk;

    trap_filter_param #(.SIZE_ADC_DATA(12), .SIZE_FILTER_DATA(28), .K_DELAY(13), .L_DELAY(7),
                        .M_COEF(0), .SIZE_TIME(8)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .input_data(input_data),
        .threshold(threshold), .output_data(s0), .out_valid(ov0), .peak_value(pv0),
        .peak_time(pt0), .peak_valid(pk0));

    trap_filter_param #(.SIZE_ADC_DATA(12), .SIZE_FILTER_DATA(28), .K_DELAY(13), .L_DELAY(7),
                        .M_COEF(16), .SIZE_TIME(8)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .input_data(input_data),
        .threshold(threshold), .output_data(s16), .out_valid(ov16), .peak_value(pv16),
        .peak_time(pt16), .peak_valid(pk16));

    trap_filter_param #(.SIZE_ADC_DATA(12), .SIZE_FILTER_DATA(28), .K_DELAY(13), .L_DELAY(7),
                        .M_COEF(0), .SIZE_TIME(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .input_data(input_data),
        .threshold(threshold), .output_data(ss), .out_valid(ovs), .peak_value(pvs),
        .peak_time(pts), .peak_valid(pks));

    int checks = 0;
    int errors = 0;
    int pk_cnt = 0;
    int pk_n = -1;
    int out_n = 0;
    bit mon_en = 1'b0;
    bit use16 = 1'b0;
    logic [3:0] iv_hist = '0;
    logic signed [27:0] exp_q[$];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Impulse response of the M=0 filter to a unit sample.
    function automatic int trap_unit(input int n);
        if (n <= 6)  return n + 1;
        if (n <= 12) return 7;
        if (n <= 19) return 19 - n;
        return 0;
    endfunction

    function automatic int s16_imp10(input int n);
        if (n <= 6)  return 170 + 10 * n;
        if (n <= 12) return 70;
        if (n <= 19) return -100 - 10 * (n - 13);
        return 0;
    endfunction

    function automatic int step_unit(input int n);
        int tab [20] = '{1, 3, 6, 10, 15, 21, 28, 35, 42, 49, 56, 63, 70, 76, 81, 85, 88, 90, 91, 91};
        if (n < 20) return tab[n];
        return 91;
    endfunction

    always @(negedge clk) begin
        logic               ov;
        logic signed [27:0] obs;
        if (pk0) begin
            pk_cnt++;
            pk_n = out_n - 1;
        end
        ov  = use16 ? ov16 : ov0;
        obs = use16 ? s16 : s0;
        if (!mon_en) begin
            iv_hist = '0;
        end else begin
            chk("out_valid_latency", 64'(ov), 64'(iv_hist[3]));
            if (ov && iv_hist[3]) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL exp_queue observed=empty expected=pending sample");
                end
                if (exp_q.size() > 0) chk("s_value", obs, exp_q.pop_front());
                out_n++;
            end
            iv_hist = {iv_hist[2:0], in_valid};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] v, input int gap);
        in_valid   = 1'b1;
        input_data = v;
        tick();
        in_valid   = 1'b0;
        input_data = '0;
        repeat (gap) tick();
    endtask

    // mode 0: impulse 100 (M=0 view); 1: impulse 10 (M=16 view); 2: constant 4095 (M=0 view)
    task automatic run(input int mode, input int gapmax);
        for (int n = 0; n < 25; n++) begin
            logic [11:0] v;
            int e;
            case (mode)
                0:       begin v = (n == 0) ? 12'd100 : 12'd0; e = 100 * trap_unit(n); end
                1:       begin v = (n == 0) ? 12'd10 : 12'd0;  e = s16_imp10(n); end
                default: begin v = 12'd4095;                   e = 4095 * step_unit(n); end
            endcase
            exp_q.push_back(28'(e));
            send(v, (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
        end
        repeat (8) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_peak(input string tag);
        chk({tag, "_count"}, 64'(pk_cnt), 64'd1);
        chk({tag, "_index"}, 64'(pk_n), 64'd17);
        chk({tag, "_value"}, pv0, 64'd700);
        chk({tag, "_time"}, 64'(pt0), 64'd4);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("rst_output_data", s0, 64'd0);
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_peak_value", pv0, 64'd0);
        chk("rst_peak_time", 64'(pt0), 64'd0);
        chk("rst_peak_valid", 64'(pk0), 64'd0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        mon_en = 1'b1;

        pk_cnt = 0; out_n = 0;
        run(0, 0);
        check_peak("pulse");
        chk("sat_peak_time", 64'(pts), 64'd3);
        chk("sat_peak_value", pvs, 64'd700);

        pk_cnt = 0; out_n = 0;
        for (int n = 0; n < 10; n++) begin
            exp_q.push_back(28'(100 * trap_unit(n)));
            send((n == 0) ? 12'd100 : 12'd0, 0);
        end
        mon_en = 1'b0;
        exp_q.delete();
        reset = 1'b0;
        #1;
        chk("abort_output_data", s0, 64'd0);
        chk("abort_out_valid", 64'(ov0), 64'd0);
        chk("abort_peak_value", pv0, 64'd0);
        chk("abort_peak_time", 64'(pt0), 64'd0);
        chk("abort_peak_valid", 64'(pk0), 64'd0);
        repeat (4) tick();
        reset = 1'b1;
        repeat (6) tick();
        chk("abort_no_peak", 64'(pk_cnt), 64'd0);
        mon_en = 1'b1;
        pk_cnt = 0; out_n = 0;
        run(0, 0);
        check_peak("rerun");

        chk("hold_peak_value", pv0, 64'd700);
        pk_cnt = 0; out_n = 0;
        run(0, 3);
        check_peak("gapped");

        threshold = 28'sd800;
        pk_cnt = 0; out_n = 0;
        run(0, 0);
        chk("high_thr_no_peak", 64'(pk_cnt), 64'd0);
        chk("high_thr_hold_value", pv0, 64'd700);

        threshold = 28'sd250;
        use16 = 1'b1;
        run(1, 0);
        use16 = 1'b0;

        mon_en = 1'b0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        mon_en = 1'b1;
        run(2, 0);
        chk("step_m16_settled", s16, 64'd372645);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=no completion expected=completion");
        $fatal(1, "bench did not complete");
    end
endmodule
